// File: rtl/id_stage_p_if.sv
// IF/ID/EX handshake, forwarding and register-file write bundle for id_stage_p.
// master drives the stage inputs; slave is the decode stage itself.
interface id_stage_p_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] npc_i;
    logic [31:0]     ir_i;
    logic [1:0]      imm_sel;
    logic            uses_rt;
    logic            flush;
    logic            ex_wr;
    logic            ex_load;
    logic [RAW-1:0]  ex_addr;
    logic [XLEN-1:0] ex_val;
    logic            mem_wr;
    logic [RAW-1:0]  mem_addr;
    logic [XLEN-1:0] mem_val;
    logic            wb_wr;
    logic [RAW-1:0]  wb_addr;
    logic [XLEN-1:0] wb_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] npc_o;
    logic [XLEN-1:0] a_o;
    logic [XLEN-1:0] b_o;
    logic [XLEN-1:0] imm_o;
    logic [31:0]     ir_o;
    logic [31:0]     stall_cnt;

    modport master (
        output in_valid, npc_i, ir_i, imm_sel, uses_rt, flush,
               ex_wr, ex_load, ex_addr, ex_val,
               mem_wr, mem_addr, mem_val,
               wb_wr, wb_addr, wb_val, out_ready,
        input  in_ready, out_valid, npc_o, a_o, b_o, imm_o, ir_o, stall_cnt
    );

    modport slave (
        input  in_valid, npc_i, ir_i, imm_sel, uses_rt, flush,
               ex_wr, ex_load, ex_addr, ex_val,
               mem_wr, mem_addr, mem_val,
               wb_wr, wb_addr, wb_val, out_ready,
        output in_ready, out_valid, npc_o, a_o, b_o, imm_o, ir_o, stall_cnt
    );
endinterface

// File: rtl/id_stage_p.sv
// Decode stage: register file read with EX/MEM/WB forwarding, immediate extension, load-use stall.
// Latency 1 cycle; ID/EX register holds under out_ready=0, one bubble per load-use hazard.
module id_stage_p #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_p_if.slave bus
);
    logic [XLEN-1:0] r_rf [2**RAW];
    logic            r_out_valid;
    logic [XLEN-1:0] r_npc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic [31:0]     r_ir;
    logic [31:0]     r_stall_cnt;

    logic [RAW-1:0]  w_src [2];
    logic [XLEN-1:0] w_opnd [2];
    logic [15:0]     w_imm16;
    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_advance;
    logic            w_load;

    // Field extraction: truncates to RAW bits when narrower, zero-extends when wider.
    assign w_src[0] = RAW'({{RAW{1'b0}}, bus.ir_i[25:21]});
    assign w_src[1] = RAW'({{RAW{1'b0}}, bus.ir_i[20:16]});

    // A load still in EX has no result yet, so it is never an EX forward source.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_opnd[k] = r_rf[w_src[k]];
            if (w_src[k] == '0)
                w_opnd[k] = '0;
            else if (bus.ex_wr && !bus.ex_load && bus.ex_addr == w_src[k])
                w_opnd[k] = bus.ex_val;
            else if (bus.mem_wr && bus.mem_addr == w_src[k])
                w_opnd[k] = bus.mem_val;
            else if (bus.wb_wr && bus.wb_addr == w_src[k])
                w_opnd[k] = bus.wb_val;
        end
    end

    assign w_imm16 = bus.ir_i[15:0];
    assign w_sext  = {{(XLEN-16){w_imm16[15]}}, w_imm16};

    always_comb begin
        w_imm = '0;
        case (bus.imm_sel)
            2'd0:    w_imm = XLEN'(w_imm16);
            2'd1:    w_imm = w_sext;
            2'd2:    w_imm = XLEN'({w_imm16, 16'h0000});
            default: w_imm = w_sext << 2;
        endcase
    end

    assign w_hazard = bus.in_valid && bus.ex_wr && bus.ex_load && (bus.ex_addr != '0) &&
                      ((bus.ex_addr == w_src[0]) || (bus.uses_rt && bus.ex_addr == w_src[1]));
    assign w_advance = !r_out_valid || bus.out_ready;
    assign w_load    = bus.in_valid && !w_hazard;

    assign bus.in_ready = bus.flush || (!w_hazard && w_advance);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**RAW; i++)
                r_rf[i] <= '0;
            r_out_valid <= 1'b0;
            r_npc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_ir        <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.wb_wr && bus.wb_addr != '0)
                r_rf[bus.wb_addr] <= bus.wb_val;

            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_advance) begin
                r_out_valid <= w_load;
                if (w_load) begin
                    r_npc <= bus.npc_i;
                    r_a   <= w_opnd[0];
                    r_b   <= w_opnd[1];
                    r_imm <= w_imm;
                    r_ir  <= bus.ir_i;
                end
            end

            if (w_hazard && !bus.flush)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.npc_o     = r_npc;
    assign bus.a_o       = r_a;
    assign bus.b_o       = r_b;
    assign bus.imm_o     = r_imm;
    assign bus.ir_o      = r_ir;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboard bench for id_stage_p: expected ID/EX payloads queued at acceptance, popped after the edge.
module tb_id_stage_p;
    typedef struct {
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] ir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_p_if #(.XLEN(32), .RAW(5)) bus ();
    id_stage_p #(.XLEN(32), .RAW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        sb_q[$];
    exp_t        last;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        m_v;
    logic [31:0] m_stall;
    logic [31:0] npc_ctr = 32'h0000_1000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic set_fwd(input logic exw, input logic exl, input logic [4:0] exa, input logic [31:0] exv,
                           input logic mw, input logic [4:0] ma, input logic [31:0] mv,
                           input logic ww, input logic [4:0] wa, input logic [31:0] wv);
        bus.ex_wr = exw;  bus.ex_load = exl; bus.ex_addr = exa;  bus.ex_val = exv;
        bus.mem_wr = mw;  bus.mem_addr = ma; bus.mem_val = mv;
        bus.wb_wr = ww;   bus.wb_addr = wa;  bus.wb_val = wv;
    endtask

    // One cycle: drive at negedge, check in_ready, clock, check registered outputs at next negedge.
    task automatic step(input logic v, input logic [31:0] ir, input logic [1:0] sel, input logic urt,
                        input logic ordy, input logic fl, input logic hz,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] eimm);
        logic exp_rdy;
        exp_t e;
        bus.in_valid = v; bus.ir_i = ir; bus.imm_sel = sel; bus.uses_rt = urt;
        bus.out_ready = ordy; bus.flush = fl; bus.npc_i = npc_ctr;
        #1;
        exp_rdy = fl | (!hz & (!m_v | ordy));
        check_val("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (fl) begin
            m_v = 1'b0;
        end else if (!m_v || ordy) begin
            m_v = v & !hz;
            if (v && !hz) begin
                e.npc = npc_ctr; e.a = ea; e.b = eb; e.imm = eimm; e.ir = ir;
                sb_q.push_back(e);
            end
        end
        if (hz && !fl) m_stall = m_stall + 32'd1;
        @(posedge clk);
        @(negedge clk);
        check_val("out_valid", 32'(bus.out_valid), 32'(m_v));
        if (sb_q.size() > 0) last = sb_q.pop_front();
        if (m_v) begin
            check_val("npc_o", bus.npc_o, last.npc);
            check_val("a_o",   bus.a_o,   last.a);
            check_val("b_o",   bus.b_o,   last.b);
            check_val("imm_o", bus.imm_o, last.imm);
            check_val("ir_o",  bus.ir_o,  last.ir);
        end
        check_val("stall_cnt", bus.stall_cnt, m_stall);
        npc_ctr = npc_ctr + 32'd4;
    endtask

    task automatic check_reset_state();
        check_val("rst out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst a_o",       bus.a_o,   32'd0);
        check_val("rst b_o",       bus.b_o,   32'd0);
        check_val("rst imm_o",     bus.imm_o, 32'd0);
        check_val("rst ir_o",      bus.ir_o,  32'd0);
        check_val("rst npc_o",     bus.npc_o, 32'd0);
        check_val("rst stall_cnt", bus.stall_cnt, 32'd0);
        m_v = 1'b0;
        m_stall = 32'd0;
        sb_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.ir_i = '0; bus.imm_sel = '0; bus.uses_rt = 1'b0;
        bus.out_ready = 1'b1; bus.flush = 1'b0; bus.npc_i = '0;
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // Register file write, then read through the array.
        set_fwd(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h1234_5678);
        step(0, 32'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(3, 0, 16'h0010), 2'd0, 0, 1, 0, 0, 32'h1234_5678, 0, 32'h10);

        // EX beats MEM; r0 never forwarded.
        set_fwd(1, 0, 5'd4, 32'd5, 1, 5'd4, 32'd9, 0, 0, 0);
        step(1, mk_ir(4, 0, 16'h0000), 2'd0, 0, 1, 0, 0, 32'd5, 0, 0);
        step(1, mk_ir(0, 4, 16'h0000), 2'd0, 0, 1, 0, 0, 0, 32'd5, 0);
        set_fwd(0, 0, 0, 0, 1, 5'd4, 32'd9, 0, 0, 0);
        step(1, mk_ir(4, 4, 16'h0000), 2'd0, 0, 1, 0, 0, 32'd9, 32'd9, 0);

        // Same-cycle WB write is forwarded, then visible from the array.
        set_fwd(0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h66);
        step(1, mk_ir(6, 3, 16'h0000), 2'd0, 0, 1, 0, 0, 32'h66, 32'h1234_5678, 0);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(6, 0, 16'h0000), 2'd0, 0, 1, 0, 0, 32'h66, 0, 0);

        // Load in EX: no forward, no hazard when rt is not a source; hazard when it is.
        set_fwd(1, 1, 5'd7, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(0, 7, 16'h0000), 2'd0, 0, 1, 0, 0, 0, 0, 0);
        step(1, mk_ir(0, 7, 16'h0000), 2'd0, 1, 1, 0, 1, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 1, 5'd7, 32'hAA, 0, 0, 0);
        step(1, mk_ir(0, 7, 16'h0000), 2'd0, 1, 1, 0, 0, 0, 32'hAA, 0);

        // Immediate modes.
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(0, 0, 16'h8004), 2'd0, 0, 1, 0, 0, 0, 0, 32'h0000_8004);
        step(1, mk_ir(0, 0, 16'h8004), 2'd1, 0, 1, 0, 0, 0, 0, 32'hFFFF_8004);
        step(1, mk_ir(0, 0, 16'h8004), 2'd2, 0, 1, 0, 0, 0, 0, 32'h8004_0000);
        step(1, mk_ir(0, 0, 16'h8004), 2'd3, 0, 1, 0, 0, 0, 0, 32'hFFFE_0010);

        // Back-pressure holds everything; flush still clears out_valid.
        step(1, mk_ir(3, 0, 16'h1111), 2'd0, 0, 1, 0, 0, 32'h1234_5678, 0, 32'h1111);
        set_fwd(0, 0, 0, 0, 1, 5'd3, 32'h9999, 0, 0, 0);
        step(1, mk_ir(6, 0, 16'h2222), 2'd0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(6, 0, 16'h3333), 2'd0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(6, 0, 16'h4444), 2'd0, 0, 0, 1, 0, 0, 0, 0);

        // Writes to r0 are dropped.
        set_fwd(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF);
        step(1, mk_ir(0, 0, 16'h0000), 2'd0, 0, 1, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(0, 0, 16'h0000), 2'd0, 0, 1, 0, 0, 0, 0, 0);

        // Flush overrides hazard: ready, no stall count.
        set_fwd(1, 1, 5'd7, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(7, 0, 16'h0000), 2'd0, 0, 1, 1, 1, 0, 0, 0);

        // Stall counter wrap from all-ones.
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        m_stall = 32'hFFFF_FFFF;
        step(1, mk_ir(7, 0, 16'h0000), 2'd0, 0, 1, 0, 1, 0, 0, 0);

        // Reset in the middle of a stalled, back-pressured cycle.
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(3, 0, 16'h0000), 2'd0, 0, 1, 0, 0, 32'h1234_5678, 0, 0);
        set_fwd(1, 1, 5'd7, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1; bus.ir_i = mk_ir(7, 0, 16'h0000); bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        step(1, mk_ir(7, 0, 16'h0000), 2'd0, 0, 1, 0, 1, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, mk_ir(3, 0, 16'h0000), 2'd0, 0, 1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode pipeline stage for the R/I/J CPU: register-file read, immediate extension, EX/MEM/WB operand forwarding, load-use hazard detection, and a valid/ready ID/EX pipeline register with flush. It sits between the IF stage and the EX stage. It owns the architectural register file, which the WB stage writes through this block.

## Interface
- XLEN, 32, datapath and instruction width (IR fields fixed at bits 31:0 regardless)
- RAW, 5, register address width; register count is 2**RAW
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  ID accepts this cycle
- npc_i  in  XLEN  next-PC of the instruction
- ir_i  in  32  instruction word
- imm_sel  in  2  0 zero-ext imm16, 1 sign-ext imm16, 2 upper (imm16<<16, low 16 zero), 3 sign-ext imm16<<2 (branch offset)
- uses_rt  in  1  instruction reads rt as a source (for hazard check)
- flush  in  1  kill the instruction in ID and in the ID/EX register
- ex_wr, ex_load  in  1 each  EX-stage instruction writes a register / is a load
- ex_addr  in  RAW;  ex_val  in  XLEN  EX destination and result
- mem_wr  in  1;  mem_addr  in  RAW;  mem_val  in  XLEN  MEM-stage write-back info
- wb_wr  in  1;  wb_addr  in  RAW;  wb_val  in  XLEN  register-file write port
- out_valid  out  1  ID/EX register holds a live instruction
- out_ready  in  1  EX accepts ID/EX contents
- npc_o, a_o, b_o, imm_o  out  XLEN each  registered next-PC, rs value, rt value, immediate
- ir_o  out  32  registered instruction
- stall_cnt  out  32  count of load-use stall cycles

## Operation
- rs = ir_i[25:21], rt = ir_i[20:16] (RAW low bits used when RAW<5, zero-extended compare when RAW>5).
- Register 0 reads 0 always. Writes to address 0 are ignored. Address 0 is never forwarded.
- Operand select per source, highest priority first:
  1. EX (ex_wr, address match, !ex_load)
  2. MEM (mem_wr, match)
  3. WB (wb_wr, match)
  4. register file
- hazard = in_valid & ex_wr & ex_load & ex_addr!=0 & (ex_addr==rs | (uses_rt & ex_addr==rt)).
- in_ready = flush | (!hazard & (!out_valid | out_ready)).
- ID/EX update each edge, priority order:
  - rst: all outputs 0, stall_cnt 0, register file cleared to 0.
  - flush: out_valid<=0. Payload is don't-care and held.
  - !out_valid | out_ready:
    - out_valid <= in_valid & !hazard.
    - Payload loads when in_valid & !hazard. Otherwise payload holds (bubble).
  - else: all held. Stall back-pressure; operands do not refresh.
- Imm: mode per imm_sel, extended to XLEN. Sign extension replicates bit 15 to XLEN-1.
- Register file write: on rising edge when wb_wr & wb_addr!=0, including during flush and stall.
- stall_cnt increments by 1 each cycle hazard & !flush. Wraps at 2**32-1 to 0.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is visible on outputs after edge N.
- A load-use hazard costs exactly one bubble cycle once the load leaves EX. The same instruction is then accepted with the load value taken from MEM forwarding.
- Same-cycle WB write and read of the same register returns wb_val via the forward path. The register file is never read stale.
- flush and hazard together: flush wins, in_ready=1, no stall_cnt increment.
- flush and out_ready=0: out_valid still cleared.
- Reset mid-stall: all state is cleared at the reset edge. in_ready after reset equals 1 if no hazard.
- No combinational path from out_ready to out_valid. in_ready depends combinationally on out_ready, flush and the hazard inputs only.

## Test plan
- Reset, then wb writes r3=0x12345678; next cycle ir_i reads rs=3 -> a_o=0x12345678, out_valid=1 one edge later.
- ex_wr=1, ex_addr=4, ex_val=5; mem_wr=1, mem_addr=4, mem_val=9; ir_i rs=4 -> a_o=5 (EX wins). Repeat with rs=0 -> a_o=0.
- ex_load=1, ex_addr=7, instruction uses rt=7 with uses_rt=1 -> in_ready=0, one bubble (out_valid=0), stall_cnt=1. Next cycle with mem_addr=7, mem_val=0xAA -> b_o=0xAA.
- imm16=0x8004: imm_sel 0 -> 0x00008004; 1 -> 0xFFFF8004; 2 -> 0x80040000; 3 -> 0xFFFE0010.
- out_ready=0 for 3 cycles with new inputs -> outputs and out_valid held, in_ready=0. flush asserted in the 3rd cycle -> out_valid=0 next edge.
- Write r0=0xFFFF via wb, then read rs=0 -> a_o=0. Preload stall_cnt to 2**32-1 via forced hazards -> wraps to 0.
